// File: rtl/mips_decode_stage_if.sv
// Bus between the decode stage and its neighbours: IF handshake, register-file read/writeback, ID/EX entry.
// The decode stage sits on the slave side; whoever drives IF/EX/writeback uses the master side.
interface mips_decode_stage_if;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        flush;
   logic [4:0]  rf_addr1;
   logic [4:0]  rf_addr2;
   logic [31:0] rf_data1;
   logic [31:0] rf_data2;
   logic        wb_ena;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_dest;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [1:0]  ex_branch;
   logic        ex_alu_src;
   logic [3:0]  ex_alu_op;
   logic        ex_illegal;

   modport slave (
      input  if_valid, if_instr, if_pc, flush, rf_data1, rf_data2,
             wb_ena, wb_addr, wb_data, ex_ready,
      output id_ready, rf_addr1, rf_addr2, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
             ex_imm, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
             ex_alu_src, ex_alu_op, ex_illegal
   );

   modport master (
      output if_valid, if_instr, if_pc, flush, rf_data1, rf_data2,
             wb_ena, wb_addr, wb_data, ex_ready,
      input  id_ready, rf_addr1, rf_addr2, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
             ex_imm, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
             ex_alu_src, ex_alu_op, ex_illegal
   );
endinterface

// File: rtl/mips_decode_stage.sv
// MIPS instruction-decode stage: register read with writeback bypass, control decode,
// load-use stall and a single ID/EX output register with valid/ready toward EX.
module mips_decode_stage (
   input  logic               clk,
   input  logic               rst,
   mips_decode_stage_if.slave bus
);

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  branch;
      logic        alu_src;
      alu_op_e     alu_op;
      logic        illegal;
   } id_ex_t;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [31:0] imm_sext, imm_zext;

   assign opcode   = bus.if_instr[31:26];
   assign rs       = bus.if_instr[25:21];
   assign rt       = bus.if_instr[20:16];
   assign rd       = bus.if_instr[15:11];
   assign shamt    = bus.if_instr[10:6];
   assign funct    = bus.if_instr[5:0];
   assign imm16    = bus.if_instr[15:0];
   assign imm_sext = {{16{imm16[15]}}, imm16};
   assign imm_zext = {16'h0000, imm16};

   assign bus.rf_addr1 = rs;
   assign bus.rf_addr2 = rt;

   // A register selector of 0 already excludes wb_addr==0 from the bypass match.
   logic [31:0] opnd_a, opnd_b;
   always_comb begin
      opnd_a = bus.rf_data1;
      opnd_b = bus.rf_data2;
      if (rs == 5'd0)                                opnd_a = '0;
      else if (bus.wb_ena && (bus.wb_addr == rs))    opnd_a = bus.wb_data;
      if (rt == 5'd0)                                opnd_b = '0;
      else if (bus.wb_ena && (bus.wb_addr == rt))    opnd_b = bus.wb_data;
   end

   id_ex_t     dec;
   logic [4:0] wr_reg;
   logic       reads_rt;

   always_comb begin
      // NOTE: every always_comb target is given a default first, so no path leaves it unassigned and no latch is inferred.
      dec         = '0;
      wr_reg      = '0;
      reads_rt    = 1'b0;
      dec.valid   = 1'b1;
      dec.pc      = bus.if_pc;
      dec.rs_data = opnd_a;
      dec.rt_data = opnd_b;
      case (opcode)
         6'h00: begin
            reads_rt = 1'b1;
            case (funct)
               6'h20, 6'h21: dec.alu_op = ALU_ADD;
               6'h22, 6'h23: dec.alu_op = ALU_SUB;
               6'h24:        dec.alu_op = ALU_AND;
               6'h25:        dec.alu_op = ALU_OR;
               6'h26:        dec.alu_op = ALU_XOR;
               6'h27:        dec.alu_op = ALU_NOR;
               6'h2A:        dec.alu_op = ALU_SLT;
               6'h00: begin dec.alu_op = ALU_SLL; dec.alu_src = 1'b1; dec.imm = {27'd0, shamt}; end
               6'h02: begin dec.alu_op = ALU_SRL; dec.alu_src = 1'b1; dec.imm = {27'd0, shamt}; end
               default:      dec.illegal = 1'b1;
            endcase
            if (!dec.illegal) wr_reg = rd;
         end
         6'h08, 6'h09: begin dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.imm = imm_sext; wr_reg = rt; end
         6'h0A: begin dec.alu_op = ALU_SLT; dec.alu_src = 1'b1; dec.imm = imm_sext; wr_reg = rt; end
         6'h0C: begin dec.alu_op = ALU_AND; dec.alu_src = 1'b1; dec.imm = imm_zext; wr_reg = rt; end
         6'h0D: begin dec.alu_op = ALU_OR;  dec.alu_src = 1'b1; dec.imm = imm_zext; wr_reg = rt; end
         6'h0E: begin dec.alu_op = ALU_XOR; dec.alu_src = 1'b1; dec.imm = imm_zext; wr_reg = rt; end
         // lui carries the raw 16-bit field; the ALU performs the shift into the upper half.
         6'h0F: begin dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; dec.imm = imm_zext; wr_reg = rt; end
         6'h23: begin
            dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.imm = imm_sext;
            dec.mem_read = 1'b1; wr_reg = rt;
         end
         6'h2B: begin
            dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.imm = imm_sext;
            dec.mem_write = 1'b1; reads_rt = 1'b1;
         end
         6'h04: begin dec.alu_op = ALU_SUB; dec.imm = imm_sext; dec.branch = 2'b01; reads_rt = 1'b1; end
         6'h05: begin dec.alu_op = ALU_SUB; dec.imm = imm_sext; dec.branch = 2'b10; reads_rt = 1'b1; end
         default: dec.illegal = 1'b1;
      endcase
      if (wr_reg != 5'd0) begin
         dec.reg_write = 1'b1;
         dec.dest      = wr_reg;
      end
   end

   id_ex_t ex_q;
   logic   hazard, adv, accept;

   assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) &
                   ((ex_q.dest == rs) | ((ex_q.dest == rt) & reads_rt));
   assign adv          = ~ex_q.valid | bus.ex_ready;
   assign bus.id_ready = adv & ~hazard & ~bus.flush;
   assign accept       = bus.if_valid & bus.id_ready;

   // Flush and stall cycles load an all-zero bubble; backpressure holds the entry untouched.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
      if (rst)            ex_q <= '0;
      else if (bus.flush) ex_q <= '0;
      else if (adv)       ex_q <= accept ? dec : '0;
   end

   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_pc        = ex_q.pc;
   assign bus.ex_rs_data   = ex_q.rs_data;
   assign bus.ex_rt_data   = ex_q.rt_data;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.ex_dest      = ex_q.dest;
   assign bus.ex_reg_write = ex_q.reg_write;
   assign bus.ex_mem_read  = ex_q.mem_read;
   assign bus.ex_mem_write = ex_q.mem_write;
   assign bus.ex_branch    = ex_q.branch;
   assign bus.ex_alu_src   = ex_q.alu_src;
   assign bus.ex_alu_op    = ex_q.alu_op;
   assign bus.ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Self-checking bench for mips_decode_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural pipeline model.
module tb_mips_decode_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_decode_stage_if bus ();

   mips_decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Register file model; $0 holds junk on purpose so the decoder must ignore it.
   logic [31:0] regs [32];
   assign bus.rf_data1 = regs[bus.rf_addr1];
   assign bus.rf_data2 = regs[bus.rf_addr2];

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  dest;
      logic        rw, mr, mw;
      logic [1:0]  br;
      logic        src;
      logic [3:0]  op;
      logic        ill;
   } entry_t;

   entry_t exp_q;
   int     vectors = 0;
   int     miscompares = 0;
   logic   last_id_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h, required %h", name, $time, act, req);
      end
   endtask

   function automatic entry_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b);
      entry_t     e;
      logic [5:0] op, fn;
      logic [4:0] tgt;
      logic [31:0] se, ze;
      op = ins[31:26];
      fn = ins[5:0];
      se = 32'($signed(ins[15:0]));
      ze = 32'(ins[15:0]);
      e = '0; e.valid = 1'b1; e.pc = pc; e.a = a; e.b = b;
      tgt = 5'd0;
      if (op == 6'h00) begin
         case (fn)
            6'h20, 6'h21: e.op = 4'd0;
            6'h22, 6'h23: e.op = 4'd1;
            6'h24: e.op = 4'd2;
            6'h25: e.op = 4'd3;
            6'h26: e.op = 4'd4;
            6'h27: e.op = 4'd5;
            6'h2A: e.op = 4'd6;
            6'h00: begin e.op = 4'd7; e.src = 1'b1; e.imm = 32'(ins[10:6]); end
            6'h02: begin e.op = 4'd8; e.src = 1'b1; e.imm = 32'(ins[10:6]); end
            default: e.ill = 1'b1;
         endcase
         if (!e.ill) tgt = ins[15:11];
      end else begin
         case (op)
            6'h08, 6'h09: begin e.op = 4'd0; e.src = 1'b1; e.imm = se; tgt = ins[20:16]; end
            6'h0A: begin e.op = 4'd6; e.src = 1'b1; e.imm = se; tgt = ins[20:16]; end
            6'h0C: begin e.op = 4'd2; e.src = 1'b1; e.imm = ze; tgt = ins[20:16]; end
            6'h0D: begin e.op = 4'd3; e.src = 1'b1; e.imm = ze; tgt = ins[20:16]; end
            6'h0E: begin e.op = 4'd4; e.src = 1'b1; e.imm = ze; tgt = ins[20:16]; end
            6'h0F: begin e.op = 4'd9; e.src = 1'b1; e.imm = ze; tgt = ins[20:16]; end
            6'h23: begin e.op = 4'd0; e.src = 1'b1; e.imm = se; e.mr = 1'b1; tgt = ins[20:16]; end
            6'h2B: begin e.op = 4'd0; e.src = 1'b1; e.imm = se; e.mw = 1'b1; end
            6'h04: begin e.op = 4'd1; e.imm = se; e.br = 2'b01; end
            6'h05: begin e.op = 4'd1; e.imm = se; e.br = 2'b10; end
            default: e.ill = 1'b1;
         endcase
      end
      if (tgt != 5'd0) begin e.rw = 1'b1; e.dest = tgt; end
      return e;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] sel);
      if (sel == 5'd0) return 32'd0;
      if (bus.wb_ena && bus.wb_addr == sel) return bus.wb_data;
      return regs[sel];
   endfunction

   task automatic compare_entry();
      check("ex_valid",     32'(bus.ex_valid),     32'(exp_q.valid));
      check("ex_pc",        bus.ex_pc,             exp_q.pc);
      check("ex_rs_data",   bus.ex_rs_data,        exp_q.a);
      check("ex_rt_data",   bus.ex_rt_data,        exp_q.b);
      check("ex_imm",       bus.ex_imm,            exp_q.imm);
      check("ex_dest",      32'(bus.ex_dest),      32'(exp_q.dest));
      check("ex_reg_write", 32'(bus.ex_reg_write), 32'(exp_q.rw));
      check("ex_mem_read",  32'(bus.ex_mem_read),  32'(exp_q.mr));
      check("ex_mem_write", 32'(bus.ex_mem_write), 32'(exp_q.mw));
      check("ex_branch",    32'(bus.ex_branch),    32'(exp_q.br));
      check("ex_alu_src",   32'(bus.ex_alu_src),   32'(exp_q.src));
      check("ex_alu_op",    32'(bus.ex_alu_op),    32'(exp_q.op));
      check("ex_illegal",   32'(bus.ex_illegal),   32'(exp_q.ill));
   endtask

   // One clock: drive inputs just after a falling edge, check the combinational outputs,
   // advance the model across the rising edge, then check the registered entry.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic rdy, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, output logic acc);
      logic       adv, haz, rdy_exp, rd_rt;
      logic [5:0] op;
      entry_t     nxt;
      bus.if_valid = v;  bus.if_instr = ins; bus.if_pc = pc;
      bus.flush    = fl; bus.ex_ready = rdy;
      bus.wb_ena   = we; bus.wb_addr  = wa;  bus.wb_data = wd;
      #1;
      op      = ins[31:26];
      rd_rt   = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
      adv     = !exp_q.valid || rdy;
      haz     = exp_q.valid && exp_q.mr && (exp_q.dest != 5'd0) &&
                ((exp_q.dest == ins[25:21]) || (rd_rt && exp_q.dest == ins[20:16]));
      rdy_exp = adv && !haz && !fl;
      last_id_ready = bus.id_ready;
      check("id_ready", 32'(bus.id_ready), 32'(rdy_exp));
      check("rf_addr1", 32'(bus.rf_addr1), 32'(ins[25:21]));
      check("rf_addr2", 32'(bus.rf_addr2), 32'(ins[20:16]));
      acc = v && rdy_exp;
      if (fl)       nxt = '0;
      else if (!adv) nxt = exp_q;
      else if (acc) nxt = model_decode(ins, pc, operand(ins[25:21]), operand(ins[20:16]));
      else          nxt = '0;
      @(posedge clk);
      #1;
      exp_q = nxt;
      if (we && wa != 5'd0) regs[wa] = wd;
      @(negedge clk);
      compare_entry();
   endtask

   function automatic logic [4:0] small_reg();
      return ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] op, fn;
      case ($urandom_range(0, 15))
         0, 1, 2, 3: op = 6'h00;
         4:  op = 6'h08;
         5:  op = 6'h09;
         6:  op = 6'h0A;
         7:  op = 6'h0C;
         8:  op = 6'h0D;
         9:  op = 6'h0E;
         10: op = 6'h0F;
         11, 12: op = 6'h23;
         13: op = 6'h2B;
         14: op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
         default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 11))
         0: fn = 6'h20;  1: fn = 6'h23;  2: fn = 6'h24;  3: fn = 6'h25;
         4: fn = 6'h26;  5: fn = 6'h27;  6: fn = 6'h2A;  7: fn = 6'h22;
         8: fn = 6'h21;  9: fn = 6'h00;  10: fn = 6'h02;
         default: fn = 6'($urandom);
      endcase
      return {op, small_reg(), small_reg(), small_reg(), 5'($urandom), fn};
   endfunction

   localparam logic [31:0] ADDI_T0 = 32'h2008_0005; // addi $t0,$zero,5
   localparam logic [31:0] LW_T1   = 32'h8FA9_0000; // lw   $t1,0($sp)
   localparam logic [31:0] ADD_T2  = 32'h0129_5020; // add  $t2,$t1,$t1
   localparam logic [31:0] ORI_T4  = 32'h340C_00FF; // ori  $t4,$zero,0xff
   localparam logic [31:0] ADDI_T3 = 32'h212B_0010; // addi $t3,$t1,0x10

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        acc, hv, fl, rdy, we;
      logic [31:0] hi, hp, pc_ctr;
      logic [4:0]  wa;

      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'hBAD0_0000;
      regs[9] = 32'h1111_2222;
      exp_q   = '0;
      rst = 1'b1;
      bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.flush = 1'b0;
      bus.ex_ready = 1'b0; bus.wb_ena = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
      #1;
      compare_entry();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset.id_ready", 32'(bus.id_ready), 32'd1);
      compare_entry();

      // addi through $zero: immediate path, $0 reads as zero despite junk in the file.
      step(1'b1, ADDI_T0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
      check("addi.valid",  32'(bus.ex_valid),     32'd1);
      check("addi.dest",   32'(bus.ex_dest),      32'd8);
      check("addi.imm",    bus.ex_imm,            32'd5);
      check("addi.alu_op", 32'(bus.ex_alu_op),    32'd0);
      check("addi.src",    32'(bus.ex_alu_src),   32'd1);
      check("addi.rw",     32'(bus.ex_reg_write), 32'd1);
      check("addi.rs0",    bus.ex_rs_data,        32'd0);

      // Load-use: one bubble, then the dependent add issues.
      step(1'b1, LW_T1,  32'h4, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
      check("lw.mem_read", 32'(bus.ex_mem_read), 32'd1);
      step(1'b1, ADD_T2, 32'h8, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
      check("luse.id_ready", 32'(last_id_ready),  32'd0);
      check("luse.bubble",   32'(bus.ex_valid),   32'd0);
      step(1'b1, ADD_T2, 32'h8, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
      check("luse.id_ready2", 32'(last_id_ready), 32'd1);
      check("luse.add_rs",    bus.ex_rs_data,     32'h1111_2222);
      check("luse.add_dest",  32'(bus.ex_dest),   32'd10);

      // EX backpressure for three cycles: entry frozen, nothing taken.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, ORI_T4, 32'hC, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
         check("stall.id_ready", 32'(last_id_ready), 32'd0);
         check("stall.pc",       bus.ex_pc,          32'h8);
      end
      step(1'b1, ORI_T4, 32'hC, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
      check("ori.pc",  bus.ex_pc,  32'hC);
      check("ori.imm", bus.ex_imm, 32'hFF);

      // Writeback bypass, then the same writeback aimed at $0 must not bypass.
      regs[9] = 32'd0;
      step(1'b1, ADDI_T3, 32'h10, 1'b0, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, acc);
      check("bypass.rs", bus.ex_rs_data, 32'hDEAD_BEEF);
      regs[9] = 32'd0;
      step(1'b1, ADDI_T3, 32'h14, 1'b0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, acc);
      check("bypass0.rs", bus.ex_rs_data, 32'd0);

      // Flush beats an otherwise acceptable instruction.
      step(1'b1, ADDI_T0, 32'h18, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, acc);
      check("flush.id_ready", 32'(last_id_ready), 32'd0);
      check("flush.valid",    32'(bus.ex_valid),  32'd0);

      // Random traffic; IF holds an instruction until it is taken or flushed.
      pc_ctr = 32'h400;
      hv = 1'b1; hi = rand_instr(); hp = pc_ctr; pc_ctr += 4;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            #2;
            rst = 1'b1;
            #1;
            exp_q = '0;
            compare_entry();
            @(negedge clk);
            rst = 1'b0;
         end
         fl  = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         we  = 1'($urandom_range(0, 1));
         wa  = small_reg();
         step(hv, hi, hp, fl, rdy, we, wa, $urandom, acc);
         if (acc || fl || !hv) begin
            hv = ($urandom_range(0, 7) != 0);
            hi = rand_instr();
            hp = pc_ctr;
            pc_ctr += 4;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
